// File: rtl/hbm_axi_channel_master.sv
// Per-pseudo-channel AXI master: single-cycle user write/read strobes become single-beat AXI
// transactions. Defining HBM_AXI_CNT_EN adds the wr_done_cnt/rd_done_cnt completion counters.
module hbm_axi_channel_master #(
  parameter int         WR_FIFO_DEPTH = 4,
  parameter logic [5:0] AXI_ID        = 6'd0,
  parameter int         ADDR_W        = 34,
  parameter int         DATA_W        = 256
) (
  input  logic                AXI_ACLK,
  input  logic                AXI_ARESET_N,
  input  logic                write_enable,
  input  logic [ADDR_W-1:0]   write_address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic                read_enable,
  input  logic [ADDR_W-1:0]   read_address,
  output logic [DATA_W-1:0]   read_data,
  output logic                read_data_valid,
  output logic                wr_overflow,
  output logic                rd_dropped,
  output logic                resp_error,
  output logic                busy,
`ifdef HBM_AXI_CNT_EN
  output logic [15:0]         wr_done_cnt,
  output logic [15:0]         rd_done_cnt,
`endif
  output logic [5:0]          AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [5:0]          BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [5:0]          ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [3:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [5:0]          RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  localparam int              PTR_W     = $clog2(WR_FIFO_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W+1)'(WR_FIFO_DEPTH);
  localparam int              HI_W      = ADDR_W - 5;

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  // Single-beat transfers: one 32-byte beat, INCR, all lanes, fixed ID.
  assign AWID    = AXI_ID;
  assign ARID    = AXI_ID;
  assign AWLEN   = 4'd0;
  assign ARLEN   = 4'd0;
  assign AWSIZE  = 3'b101;
  assign ARSIZE  = 3'b101;
  assign AWBURST = 2'b01;
  assign ARBURST = 2'b01;
  assign WSTRB   = '1;
  assign WLAST   = 1'b1;

  // IDs and RLAST carry no information for single-beat, single-outstanding traffic.
  logic unused_inputs;
  assign unused_inputs = ^{BID, RID, RLAST, write_address[4:0], read_address[4:0]};

  // ---------------- write request FIFO ----------------
  logic [HI_W-1:0]   fifo_addr [WR_FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WR_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_count;
  logic              fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == DEPTH_CNT);
  // A pop on the same edge frees the slot the push needs.
  assign push       = write_enable && (!fifo_full || pop);

  // NOTE: storage array has no reset; only pointers and count define its contents.
  always_ff @(posedge AXI_ACLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= write_address[ADDR_W-1:5];
      fifo_data[wr_ptr] <= write_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
    if (!AXI_ARESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- write FSM ----------------
  w_state_t        w_state, w_state_nx;
  logic            awvalid_nx, wvalid_nx, bready_nx, b_err;
  logic [HI_W-1:0] aw_addr_hi;

  assign AWADDR = {aw_addr_hi, 5'b0};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nx = w_state;
    awvalid_nx = AWVALID;
    wvalid_nx  = WVALID;
    bready_nx  = BREADY;
    pop        = 1'b0;
    b_err      = 1'b0;
    case (w_state)
      W_IDLE: if (!fifo_empty) begin
        pop        = 1'b1;
        awvalid_nx = 1'b1;
        wvalid_nx  = 1'b1;
        w_state_nx = W_SEND;
      end
      W_SEND: begin
        // AW and W retire independently; B is accepted only once both are gone.
        awvalid_nx = AWVALID && !AWREADY;
        wvalid_nx  = WVALID && !WREADY;
        if (!awvalid_nx && !wvalid_nx) begin
          bready_nx  = 1'b1;
          w_state_nx = W_RESP;
        end
      end
      W_RESP: if (BVALID) begin
        bready_nx  = 1'b0;
        b_err      = (BRESP != 2'b00);
        w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  // ---------------- read FSM ----------------
  r_state_t        r_state, r_state_nx;
  logic            arvalid_nx, rready_nx, ar_load, r_fire, r_err, rd_drop;
  logic [HI_W-1:0] ar_addr_hi;

  assign ARADDR  = {ar_addr_hi, 5'b0};
  assign rd_drop = read_enable && (r_state != R_IDLE);

  always_comb begin
    r_state_nx = r_state;
    arvalid_nx = ARVALID;
    rready_nx  = RREADY;
    ar_load    = 1'b0;
    r_fire     = 1'b0;
    r_err      = 1'b0;
    case (r_state)
      R_IDLE: if (read_enable) begin
        ar_load    = 1'b1;
        arvalid_nx = 1'b1;
        r_state_nx = R_ADDR;
      end
      R_ADDR: if (ARREADY) begin
        arvalid_nx = 1'b0;
        rready_nx  = 1'b1;
        r_state_nx = R_DATA;
      end
      R_DATA: if (RVALID) begin
        r_fire     = 1'b1;
        r_err      = (RRESP != 2'b00);
        rready_nx  = 1'b0;
        r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  assign busy = !fifo_empty || (w_state != W_IDLE) || (r_state != R_IDLE);

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
    if (!AXI_ARESET_N) begin
      w_state         <= W_IDLE;
      r_state         <= R_IDLE;
      AWVALID         <= 1'b0;
      WVALID          <= 1'b0;
      BREADY          <= 1'b0;
      ARVALID         <= 1'b0;
      RREADY          <= 1'b0;
      aw_addr_hi      <= '0;
      WDATA           <= '0;
      ar_addr_hi      <= '0;
      read_data       <= '0;
      read_data_valid <= 1'b0;
      wr_overflow     <= 1'b0;
      rd_dropped      <= 1'b0;
      resp_error      <= 1'b0;
    end else begin
      w_state         <= w_state_nx;
      r_state         <= r_state_nx;
      AWVALID         <= awvalid_nx;
      WVALID          <= wvalid_nx;
      BREADY          <= bready_nx;
      ARVALID         <= arvalid_nx;
      RREADY          <= rready_nx;
      read_data_valid <= r_fire;
      if (pop) begin
        aw_addr_hi <= fifo_addr[rd_ptr];
        WDATA      <= fifo_data[rd_ptr];
      end
      if (ar_load)                wr_overflow <= wr_overflow;
      if (ar_load)                ar_addr_hi  <= read_address[ADDR_W-1:5];
      if (r_fire)                 read_data   <= RDATA;
      if (write_enable && !push)  wr_overflow <= 1'b1;
      if (rd_drop)                rd_dropped  <= 1'b1;
      if (b_err || r_err)         resp_error  <= 1'b1;
    end
  end

`ifdef HBM_AXI_CNT_EN
  // Completion counters saturate rather than wrap.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
    if (!AXI_ARESET_N) begin
      wr_done_cnt <= '0;
      rd_done_cnt <= '0;
    end else begin
      if (w_state == W_RESP && BVALID && wr_done_cnt != 16'hFFFF) wr_done_cnt <= wr_done_cnt + 16'd1;
      if (r_fire && rd_done_cnt != 16'hFFFF)                       rd_done_cnt <= rd_done_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hbm_axi_channel_master.sv
// Self-checking bench for hbm_axi_channel_master: a transaction-level model (queue of pending
// writes plus handshake flags) is compared against the DUT on every falling clock edge.
`timescale 1ns/1ps
module tb_hbm_axi_channel_master;
  localparam int ADDR_W = 34;
  localparam int DATA_W = 256;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              write_enable = 0, read_enable = 0;
  logic [ADDR_W-1:0] write_address = '0, read_address = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic              AWREADY = 0, WREADY = 0, ARREADY = 0;
  logic [5:0]        BID = '0, RID = '0;
  logic [1:0]        BRESP = '0, RRESP = '0;
  logic              BVALID = 0, RVALID = 0, RLAST = 0;
  logic [DATA_W-1:0] RDATA = '0;

  logic [DATA_W-1:0]   read_data, WDATA;
  logic                read_data_valid, wr_overflow, rd_dropped, resp_error, busy;
  logic [5:0]          AWID, ARID;
  logic [ADDR_W-1:0]   AWADDR, ARADDR;
  logic [3:0]          AWLEN, ARLEN;
  logic [2:0]          AWSIZE, ARSIZE;
  logic [1:0]          AWBURST, ARBURST;
  logic                AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY;
  logic [DATA_W/8-1:0] WSTRB;
`ifdef HBM_AXI_CNT_EN
  logic [15:0]         wr_done_cnt, rd_done_cnt;
`endif

  hbm_axi_channel_master dut (
    .AXI_ACLK(clk), .AXI_ARESET_N(rst_n),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .read_enable(read_enable), .read_address(read_address),
    .read_data(read_data), .read_data_valid(read_data_valid),
    .wr_overflow(wr_overflow), .rd_dropped(rd_dropped), .resp_error(resp_error), .busy(busy),
`ifdef HBM_AXI_CNT_EN
    .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt),
`endif
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               m_q[$];
  logic              m_wr_active = 0, m_aw = 0, m_w = 0, m_b = 0;
  logic [ADDR_W-1:0] m_awaddr = '0, m_araddr = '0;
  logic [DATA_W-1:0] m_wdata = '0, m_rdata = '0;
  logic              m_ar = 0, m_rr = 0, m_rdv = 0;
  logic              m_ovf = 0, m_drop = 0, m_err = 0;
  int                m_wr_done = 0, m_rd_done = 0;

  always @(posedge clk or negedge rst_n) begin : model_step
    bit  take;
    wr_t e;
    if (!rst_n) begin
      m_q.delete();
      m_wr_active = 0; m_aw = 0; m_w = 0; m_b = 0;
      m_ar = 0; m_rr = 0; m_rdv = 0; m_rdata = '0;
      m_ovf = 0; m_drop = 0; m_err = 0; m_wr_done = 0; m_rd_done = 0;
    end else begin
      take  = !m_wr_active && (m_q.size() != 0);
      m_rdv = 0;
      if (m_wr_active) begin
        if (m_b) begin
          if (BVALID) begin
            m_b = 0; m_wr_active = 0;
            if (BRESP != 2'b00) m_err = 1;
            if (m_wr_done < 65535) m_wr_done++;
          end
        end else begin
          if (AWREADY) m_aw = 0;
          if (WREADY)  m_w  = 0;
          if (!m_aw && !m_w) m_b = 1;
        end
      end
      if (take) begin
        e = m_q.pop_front();
        m_awaddr = e.addr & ~34'h1F;
        m_wdata  = e.data;
        m_wr_active = 1; m_aw = 1; m_w = 1;
      end
      if (write_enable) begin
        if (m_q.size() < DEPTH) m_q.push_back({write_address, write_data});
        else m_ovf = 1;
      end
      if (read_enable && (m_ar || m_rr)) m_drop = 1;
      if (m_ar) begin
        if (ARREADY) begin m_ar = 0; m_rr = 1; end
      end else if (m_rr) begin
        if (RVALID) begin
          m_rr = 0; m_rdv = 1; m_rdata = RDATA;
          if (RRESP != 2'b00) m_err = 1;
          if (m_rd_done < 65535) m_rd_done++;
        end
      end else if (read_enable) begin
        m_ar = 1;
        m_araddr = read_address & ~34'h1F;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("awvalid", AWVALID, m_aw);
    check("wvalid", WVALID, m_w);
    check("bready", BREADY, m_b);
    check("arvalid", ARVALID, m_ar);
    check("rready", RREADY, m_rr);
    check("read_data_valid", read_data_valid, m_rdv);
    check("read_data", read_data, m_rdata);
    check("wr_overflow", wr_overflow, m_ovf);
    check("rd_dropped", rd_dropped, m_drop);
    check("resp_error", resp_error, m_err);
    check("busy", busy, (m_q.size() != 0) || m_wr_active || m_ar || m_rr);
    if (m_aw) begin
      check("awaddr", AWADDR, m_awaddr);
      check("aw_const", {AWID, AWLEN, AWSIZE, AWBURST}, {6'd0, 4'd0, 3'b101, 2'b01});
    end
    if (m_w) begin
      check("wdata", WDATA, m_wdata);
      check("w_const", {WSTRB, WLAST}, {{(DATA_W/8){1'b1}}, 1'b1});
    end
    if (m_ar) begin
      check("araddr", ARADDR, m_araddr);
      check("ar_const", {ARID, ARLEN, ARSIZE, ARBURST}, {6'd0, 4'd0, 3'b101, 2'b01});
    end
`ifdef HBM_AXI_CNT_EN
    check("wr_done_cnt", wr_done_cnt, 16'(m_wr_done));
    check("rd_done_cnt", rd_done_cnt, 16'(m_rd_done));
`endif
  end

  // ---------------- bus monitor ----------------
  logic [ADDR_W-1:0] aw_log[$];
  int aw_hi_cycles = 0;
  int rdv_cycles = 0;
  always @(negedge clk) begin
    if (rst_n && AWVALID && AWREADY) aw_log.push_back(AWADDR);
    if (AWVALID) aw_hi_cycles++;
    if (read_data_valid) rdv_cycles++;
  end

  // ---------------- slave responders ----------------
  int                b_delay = 3;
  logic [1:0]        b_resp = 2'b00;
  int                r_delay = 10;
  logic [DATA_W-1:0] r_data = '0;

  initial forever begin
    @(posedge clk); #1;
    if (rst_n && BREADY) begin
      cyc(b_delay);
      BVALID = 1; BRESP = b_resp;
      cyc(1);
      BVALID = 0; BRESP = 2'b00;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rst_n && RREADY) begin
      cyc(r_delay);
      RVALID = 1; RDATA = r_data; RLAST = 1;
      cyc(1);
      RVALID = 0; RLAST = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin
      cyc(1);
      n++;
    end
    check({name, "_idle_budget"}, (n < 300), 1'b1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    write_enable = 1; write_address = a; write_data = d;
    cyc(1);
    write_enable = 0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int base, hi0, rdv0, n, wd0;
    cyc(3);
    check("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, read_data_valid}, 6'b0);
    check("rst_flags", {wr_overflow, rd_dropped, resp_error, busy}, 4'b0);
    check("rst_read_data", read_data, 256'h0);
    rst_n = 1;
    cyc(2);

    // single write, unaligned address
    AWREADY = 1; WREADY = 1; b_delay = 3;
    base = aw_log.size(); hi0 = aw_hi_cycles;
    do_write(34'h0_2000_0013, '1);
    check("t1_awvalid_not_yet", AWVALID, 1'b0);
    cyc(1);
    check("t1_awvalid_latency", AWVALID, 1'b1);
    wait_idle("t1");
    check("t1_aw_count", aw_log.size() - base, 1);
    check("t1_awaddr", aw_log[base], 34'h0_2000_0000);
    check("t1_awvalid_cycles", aw_hi_cycles - hi0, 1);
    check("t1_bready_low", BREADY, 1'b0);
    check("t1_busy_low", busy, 1'b0);

    // burst of 16 writes against a stalled AW channel
    base = aw_log.size();
    fork
      begin AWREADY = 0; cyc(40); AWREADY = 1; end
      begin
        for (int i = 0; i < 16; i++) begin
          do_write(ADDR_W'(i * 32), DATA_W'(32'h4920 + i));
          cyc(2);
        end
      end
    join
    check("t2_overflow", wr_overflow, 1'b1);
    wait_idle("t2");
    check("t2_at_least_5", (aw_log.size() - base) >= 5, 1'b1);
    if (aw_log.size() - base >= 5)
      for (int k = 0; k < 5; k++) check("t2_aw_order", aw_log[base + k], ADDR_W'(k * 32));

    // AW accepted 5 cycles before W
    AWREADY = 0; WREADY = 0;
    do_write(34'h1_0000_0047, {8{32'hCAFE_0003}});
    cyc(3);
    AWREADY = 1;
    cyc(2);
    check("t3_aw_dropped", AWVALID, 1'b0);
    check("t3_w_held", WVALID, 1'b1);
    check("t3_no_bready", BREADY, 1'b0);
    check("t3_wdata", WDATA, {8{32'hCAFE_0003}});
    cyc(3);
    check("t3_w_still_held", WVALID, 1'b1);
    check("t3_wdata_stable", WDATA, {8{32'hCAFE_0003}});
    WREADY = 1;
    wait_idle("t3");

    // read with a dropped second request and a simultaneous write
    ARREADY = 1; r_delay = 10; r_data = 256'h4920; rdv0 = rdv_cycles;
    read_enable = 1; read_address = '0;
    write_enable = 1; write_address = 34'h0_0000_1000; write_data = 256'h77;
    cyc(1);
    read_enable = 0; write_enable = 0;
    check("t4_rd_not_dropped_yet", rd_dropped, 1'b0);
    cyc(3);
    read_enable = 1; read_address = 34'h40;
    cyc(1);
    read_enable = 0;
    check("t4_rd_dropped", rd_dropped, 1'b1);
    n = 0;
    while (!read_data_valid && n < 100) begin cyc(1); n++; end
    check("t4_rdv_seen", (n < 100), 1'b1);
    check("t4_read_data", read_data, 256'h4920);
    cyc(1);
    check("t4_rdv_one_cycle", read_data_valid, 1'b0);
    wait_idle("t4");
    check("t4_rdv_cycles", rdv_cycles - rdv0, 1);

    // error response
    check("t5_no_err_yet", resp_error, 1'b0);
    b_resp = 2'b10; wd0 = m_wr_done;
    do_write(34'h0_0000_2000, 256'h1);
    wait_idle("t5a");
    check("t5_resp_error", resp_error, 1'b1);
`ifdef HBM_AXI_CNT_EN
    check("t5_cnt_counts_err", wr_done_cnt, 16'(wd0 + 1));
`endif
    b_resp = 2'b00;
    do_write(34'h0_0000_2020, 256'h2);
    wait_idle("t5b");
    check("t5_resp_error_sticky", resp_error, 1'b1);

    // asynchronous reset while in WSEND
    AWREADY = 0; WREADY = 0;
    do_write(34'h3_0000_0100, 256'h5A);
    cyc(3);
    check("t6_in_send", {AWVALID, WVALID}, 2'b11);
    #2 rst_n = 0;
    #1;
    check("t6_async_valids", {AWVALID, WVALID}, 2'b00);
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_flags", {wr_overflow, rd_dropped, resp_error}, 3'b000);
    cyc(2);
    rst_n = 1;
    AWREADY = 1; WREADY = 1;
    cyc(1);
    base = aw_log.size();
    do_write(34'h0_0000_027F, 256'h99);
    cyc(1);
    check("t6_restart_awvalid", AWVALID, 1'b1);
    wait_idle("t6");
    check("t6_restart_count", aw_log.size() - base, 1);
    check("t6_restart_awaddr", aw_log[base], 34'h0_0000_0260);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
